adpll_lock_detect: RTL and testbench



---
 rtl/adpll_pkg.sv | 20 ++
 rtl/adpll_sync_edge.sv | 28 ++
 rtl/adpll_lock_detect.sv | 161 ++++++++++++++++
 tb/tb_adpll_lock_detect.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared types and widths for the ADPLL lock-detect slice.
`timescale 1ns/1ps
package adpll_pkg;

    localparam int MAG_W  = 5;
    localparam int SLIP_W = 8;

    typedef enum logic [1:0] {
        NO_REF = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } lock_state_t;

    // SLIP is still reported as locked, so it matters for slip accounting too.
    function automatic logic is_lock_state(input lock_state_t s);
        return (s == LOCKED) || (s == SLIP);
    endfunction

endpackage

// File: rtl/adpll_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a registered rising-edge pulse.
`timescale 1ns/1ps
module adpll_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            last_q     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[STAGES-2:0], async_in};
            last_q     <= sync_q[STAGES-1];
            rise_pulse <= sync_q[STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/adpll_lock_detect.sv
// ADPLL lock detector: per-reference-edge tolerance check with lock/unlock hysteresis,
// reference-loss watchdog, peak-error and slip diagnostics.
`timescale 1ns/1ps
module adpll_lock_detect
    import adpll_pkg::*;
#(
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_CNT  = 4,
    parameter int REF_TIMEOUT = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_ref,
    input  logic [MAG_W-1:0]  filter_out,
    input  logic              filter_sign,
    input  logic [MAG_W-1:0]  tol,
    input  logic              stat_clr,
    output logic              locked,
    output logic [1:0]        lock_state,
    output logic              ref_lost,
    output logic [MAG_W-1:0]  err_peak,
    output logic [SLIP_W-1:0] slip_cnt
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
    localparam int TMR_W  = $clog2(REF_TIMEOUT);

    localparam logic [GOOD_W-1:0] GOOD_LAST   = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  UNLOCK_LAST = BAD_W'(UNLOCK_CNT - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX     = TMR_W'(REF_TIMEOUT - 1);

    lock_state_t       state_q;
    logic [GOOD_W-1:0] good_q;
    logic [BAD_W-1:0]  bad_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              ref_evt;
    logic              in_tol;
    logic              timeout;
    logic              sample_evt;
    logic              slip_evt;
    logic              unused_sign;

    // Magnitude-only comparison: the loop-filter sign never affects lock.
    assign unused_sign = filter_sign;
    assign lock_state  = state_q;

    adpll_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_ref_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (clk_ref),
        .rise_pulse (ref_evt)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        in_tol     = (filter_out <= tol);
        timeout    = (tmr_q == TMR_MAX) && !ref_evt;
        sample_evt = ref_evt && (state_q != NO_REF);
        slip_evt   = 1'b0;
        if (timeout) begin
            slip_evt = is_lock_state(state_q);
        end else if (ref_evt && !in_tol) begin
            if (state_q == LOCKED && UNLOCK_CNT == 1)
                slip_evt = 1'b1;
            else if (state_q == SLIP && bad_q == UNLOCK_LAST)
                slip_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else if (ref_evt) begin
            tmr_q <= '0;
        end else if (tmr_q != TMR_MAX) begin
            tmr_q <= tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NO_REF;
            good_q   <= '0;
            bad_q    <= '0;
            locked   <= 1'b0;
            ref_lost <= 1'b0;
        end else if (timeout) begin
            state_q  <= NO_REF;
            good_q   <= '0;
            bad_q    <= '0;
            locked   <= 1'b0;
            ref_lost <= 1'b1;
        end else if (ref_evt) begin
            ref_lost <= 1'b0;
            case (state_q)
                NO_REF: begin
                    state_q <= ACQ;
                    good_q  <= '0;
                end
                ACQ: begin
                    if (!in_tol) begin
                        good_q <= '0;
                    end else if (good_q == GOOD_LAST) begin
                        state_q <= LOCKED;
                        good_q  <= '0;
                        locked  <= 1'b1;
                    end else begin
                        good_q <= good_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!in_tol) begin
                        if (UNLOCK_CNT == 1) begin
                            state_q <= ACQ;
                            good_q  <= '0;
                            locked  <= 1'b0;
                        end else begin
                            state_q <= SLIP;
                            bad_q   <= BAD_W'(1);
                        end
                    end
                end
                SLIP: begin
                    if (in_tol) begin
                        state_q <= LOCKED;
                        bad_q   <= '0;
                    end else if (bad_q == UNLOCK_LAST) begin
                        state_q <= ACQ;
                        good_q  <= '0;
                        bad_q   <= '0;
                        locked  <= 1'b0;
                    end else begin
                        bad_q <= bad_q + 1'b1;
                    end
                end
                default: state_q <= NO_REF;
            endcase
        end
    end

    // A clear coincident with a sample or slip keeps that event rather than dropping it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_peak <= '0;
            slip_cnt <= '0;
        end else if (stat_clr) begin
            err_peak <= sample_evt ? filter_out : '0;
            slip_cnt <= slip_evt ? SLIP_W'(1) : '0;
        end else begin
            if (sample_evt && (filter_out > err_peak))
                err_peak <= filter_out;
            if (slip_evt && (slip_cnt != '1))
                slip_cnt <= slip_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_adpll_lock_detect.sv
// Directed self-checking bench for adpll_lock_detect with default parameters.
`timescale 1ns/1ps
module tb_adpll_lock_detect;

    logic       clk;
    logic       rst_n;
    logic       clk_ref;
    logic [4:0] filter_out;
    logic       filter_sign;
    logic [4:0] tol;
    logic       stat_clr;
    logic       locked;
    logic [1:0] lock_state;
    logic       ref_lost;
    logic [4:0] err_peak;
    logic [7:0] slip_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    adpll_lock_detect dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_ref     (clk_ref),
        .filter_out  (filter_out),
        .filter_sign (filter_sign),
        .tol         (tol),
        .stat_clr    (stat_clr),
        .locked      (locked),
        .lock_state  (lock_state),
        .ref_lost    (ref_lost),
        .err_peak    (err_peak),
        .slip_cnt    (slip_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clk_ref period of 2*half clk cycles; inputs are held for the whole period.
    // With clr set, stat_clr is high exactly in the cycle the resulting ref_evt is high.
    task automatic send_evt(input logic [4:0] mag, input logic sgn, input int half, input logic clr);
        @(negedge clk);
        filter_out  = mag;
        filter_sign = sgn;
        clk_ref     = 1'b1;
        stat_clr    = 1'b0;
        for (int i = 1; i <= 2 * half; i++) begin
            @(negedge clk);
            if (i == half) clk_ref = 1'b0;
            stat_clr = clr && (i == 3);
        end
        stat_clr = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [4:0] mag, input int half);
        for (int i = 0; i < n; i++) send_evt(mag, 1'b0, half, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        clk_ref     = 1'b0;
        filter_out  = 5'd0;
        filter_sign = 1'b0;
        tol         = 5'd3;
        stat_clr    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_locked",   8'(locked),     8'd0);
        check("rst_state",    8'(lock_state), 8'd0);
        check("rst_ref_lost", 8'(ref_lost),   8'd0);
        check("rst_err_peak", 8'(err_peak),   8'd0);
        check("rst_slip_cnt", slip_cnt,       8'd0);
        rst_n = 1'b1;

        // 1. Acquisition at a 40-clk reference period.
        send_evt(5'd2, 1'b0, 20, 1'b0);
        check("acq_first_evt_state", 8'(lock_state), 8'd1);
        check("acq_first_evt_peak",  8'(err_peak),   8'd0);
        send_n(15, 5'd2, 20);
        check("acq_16th_locked", 8'(locked),     8'd0);
        check("acq_16th_state",  8'(lock_state), 8'd1);
        send_evt(5'd2, 1'b0, 20, 1'b0);
        check("acq_17th_locked", 8'(locked),     8'd1);
        check("acq_17th_state",  8'(lock_state), 8'd2);
        check("acq_slip_cnt",    slip_cnt,       8'd0);
        check("acq_err_peak",    8'(err_peak),   8'd2);

        // 2. Hysteresis: three bad events hold lock, a good one restores LOCKED.
        send_evt(5'd9, 1'b0, 3, 1'b0);
        check("hyst_slip_state",  8'(lock_state), 8'd3);
        check("hyst_slip_locked", 8'(locked),     8'd1);
        send_n(2, 5'd9, 3);
        check("hyst_3bad_state",  8'(lock_state), 8'd3);
        send_evt(5'd1, 1'b0, 3, 1'b0);
        check("hyst_recover_state",  8'(lock_state), 8'd2);
        check("hyst_recover_locked", 8'(locked),     8'd1);
        send_n(3, 5'd9, 3);
        check("hyst_3of4_locked", 8'(locked), 8'd1);
        send_evt(5'd9, 1'b0, 3, 1'b0);
        check("unlock_state",  8'(lock_state), 8'd1);
        check("unlock_locked", 8'(locked),     8'd0);
        check("unlock_slips",  slip_cnt,       8'd1);
        check("unlock_peak",   8'(err_peak),   8'd9);

        // 3. Tolerance boundary: magnitude equal to tol is good, one above restarts the run.
        tol = 5'd5;
        send_n(9, 5'd5, 3);
        send_evt(5'd6, 1'b0, 3, 1'b0);
        send_n(15, 5'd5, 3);
        check("tol_restart_15_locked", 8'(locked), 8'd0);
        send_evt(5'd5, 1'b0, 3, 1'b0);
        check("tol_restart_16_locked", 8'(locked),     8'd1);
        check("tol_restart_16_state",  8'(lock_state), 8'd2);
        tol = 5'd0;
        send_evt(5'd1, 1'b0, 3, 1'b0);
        check("tol0_mag1_state", 8'(lock_state), 8'd3);
        send_evt(5'd0, 1'b1, 3, 1'b0);
        check("tol0_neg_zero_state", 8'(lock_state), 8'd2);

        // 4. Reference loss: last ref_evt was consumed 2 clks before send_evt returned.
        repeat (1021) @(posedge clk);
        @(negedge clk);
        check("wd_before_ref_lost", 8'(ref_lost), 8'd0);
        check("wd_before_locked",   8'(locked),   8'd1);
        @(negedge clk);
        check("wd_ref_lost", 8'(ref_lost),   8'd1);
        check("wd_locked",   8'(locked),     8'd0);
        check("wd_state",    8'(lock_state), 8'd0);
        check("wd_slips",    slip_cnt,       8'd2);
        repeat (20) @(negedge clk);
        check("wd_sticky_ref_lost", 8'(ref_lost), 8'd1);
        check("wd_slip_once",       slip_cnt,     8'd2);
        send_evt(5'd0, 1'b0, 3, 1'b0);
        check("wd_restart_ref_lost", 8'(ref_lost),   8'd0);
        check("wd_restart_state",    8'(lock_state), 8'd1);

        // 5. Peak tracking and statistics clear.
        tol = 5'd3;
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("clr_peak",  8'(err_peak), 8'd0);
        check("clr_slips", slip_cnt,     8'd0);
        send_evt(5'd4,  1'b0, 3, 1'b0);
        send_evt(5'd12, 1'b0, 3, 1'b0);
        send_evt(5'd7,  1'b0, 3, 1'b0);
        check("peak_max", 8'(err_peak), 8'd12);
        send_evt(5'd3, 1'b0, 3, 1'b1);
        check("peak_clr_with_sample", 8'(err_peak), 8'd3);
        send_evt(5'd9, 1'b0, 3, 1'b0);
        for (int i = 0; i < 260; i++) begin
            send_n(16, 5'd2, 3);
            send_n(4, 5'd9, 3);
            if (i == 254) check("slips_255", slip_cnt, 8'd255);
        end
        check("slips_saturated", slip_cnt,       8'd255);
        check("slips_state",     8'(lock_state), 8'd1);
        send_n(16, 5'd2, 3);
        send_n(3, 5'd9, 3);
        send_evt(5'd9, 1'b0, 3, 1'b1);
        check("clr_with_slip_cnt",  slip_cnt,       8'd1);
        check("clr_with_slip_peak", 8'(err_peak),   8'd9);
        check("clr_with_slip_state", 8'(lock_state), 8'd1);

        // 6. Asynchronous reset while in SLIP with two bad events counted.
        send_n(16, 5'd2, 3);
        send_n(2, 5'd9, 3);
        check("pre_rst_state",  8'(lock_state), 8'd3);
        check("pre_rst_locked", 8'(locked),     8'd1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_locked", 8'(locked),     8'd0);
        check("async_rst_state",  8'(lock_state), 8'd0);
        check("async_rst_lost",   8'(ref_lost),   8'd0);
        check("async_rst_peak",   8'(err_peak),   8'd0);
        check("async_rst_slips",  slip_cnt,       8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_evt(5'd2, 1'b0, 3, 1'b0);
        check("post_rst_state",  8'(lock_state), 8'd1);
        check("post_rst_locked", 8'(locked),     8'd0);
        check("post_rst_peak",   8'(err_peak),   8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
